// File: rtl/keypad_pkg.sv
// Shared constants, row-state type and helpers for the 4x4 keypad matrix scanner.
// Includes the ghost-pattern check used when KEYPAD_GHOST_REJECT_EN is defined.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int NUM_KEYS = 16;

    typedef enum logic [1:0] {
        ROW0 = 2'd0,
        ROW1 = 2'd1,
        ROW2 = 2'd2,
        ROW3 = 2'd3
    } row_state_t;

    function automatic logic [NUM_ROWS-1:0] row_drive(input row_state_t r);
        return ~(4'b0001 << r);
    endfunction

    function automatic logic [3:0] key_index(input logic [1:0] r, input logic [1:0] c);
        return 4'(r * NUM_COLS + c);
    endfunction

    // Two rows sharing two or more closed columns form a rectangle whose fourth corner is ambiguous.
    function automatic logic ghost_detect(input logic [NUM_KEYS-1:0] scan);
        logic                g;
        logic [NUM_COLS-1:0] common;
        g = 1'b0;
        for (int a = 0; a < NUM_ROWS; a++) begin
            for (int b = a + 1; b < NUM_ROWS; b++) begin
                common = scan[a*NUM_COLS +: NUM_COLS] & scan[b*NUM_COLS +: NUM_COLS];
                if ($countones(common) >= 2) begin
                    g = 1'b1;
                end
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/keypad_matrix_scanner_scan_tick_gen.sv
// Row-slot prescaler: tick is high on the last cycle of every CLK_DIV-cycle slot.
module scan_tick_gen
    import keypad_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int             TW   = $clog2(CLK_DIV);
    localparam logic [TW-1:0]  LAST = TW'(CLK_DIV - 1);

    logic [TW-1:0] tick_cnt_r;

    // Free-running slot counter, wraps at CLK_DIV-1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_r <= '0;
        end else if (tick_cnt_r == LAST) begin
            tick_cnt_r <= '0;
        end else begin
            tick_cnt_r <= tick_cnt_r + TW'(1);
        end
    end

    assign tick = (tick_cnt_r == LAST);

endmodule

// File: rtl/keypad_matrix_scanner.sv
// 4x4 keypad row scanner with whole-scan debounce; bit i of keys feeds key_i of the encoder.
// Optional macro KEYPAD_GHOST_REJECT_EN adds rectangle (ghost) rejection and the ghost output.
module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter int CLK_DIV        = 4,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_COLS-1:0] col_in,
    output logic [NUM_ROWS-1:0] row_out,
    output logic [NUM_KEYS-1:0] keys,
    output logic                key_valid,
    output logic                key_event
`ifdef KEYPAD_GHOST_REJECT_EN
   ,output logic                ghost
`endif
);

    localparam int            SW         = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS - 1);

    logic                tick_s;
    row_state_t          row_state_r;
    row_state_t          row_next_s;
    logic [NUM_KEYS-1:0] raw_r;
    logic [NUM_KEYS-1:0] prev_raw_r;
    logic [SW-1:0]       stable_cnt_r;
    logic [SW-1:0]       stable_next_s;
    logic                scan_done_r;
    logic                ghosted_s;
    logic                update_s;

    scan_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick_s)
    );

    // Next row in the scan rotation
    always_comb begin
        row_next_s = ROW0;
        case (row_state_r)
            ROW0:    row_next_s = ROW1;
            ROW1:    row_next_s = ROW2;
            ROW2:    row_next_s = ROW3;
            ROW3:    row_next_s = ROW0;
            default: row_next_s = ROW0;
        endcase
    end

    // Row FSM: sample columns at slot end, then drive the next row
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_state_r <= ROW0;
            row_out     <= 4'b1110;
            raw_r       <= '0;
            scan_done_r <= 1'b0;
        end else begin
            scan_done_r <= 1'b0;
            if (tick_s) begin
                raw_r[key_index(row_state_r, 2'd0) +: NUM_COLS] <= ~col_in;
                row_state_r <= row_next_s;
                row_out     <= row_drive(row_next_s);
                scan_done_r <= (row_state_r == ROW3);
            end
        end
    end

    // Stability counting and update decision for the just-completed scan
    always_comb begin
        ghosted_s = 1'b0;
`ifdef KEYPAD_GHOST_REJECT_EN
        ghosted_s = ghost_detect(raw_r);
`endif
        if (ghosted_s || (raw_r != prev_raw_r)) begin
            stable_next_s = '0;
        end else if (stable_cnt_r == STABLE_MAX) begin
            stable_next_s = stable_cnt_r;
        end else begin
            stable_next_s = stable_cnt_r + SW'(1);
        end
        update_s = scan_done_r && !ghosted_s && (stable_next_s == STABLE_MAX) && (raw_r != keys);
    end

    // Debounced outputs, updated on the cycle after scan completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_raw_r   <= '0;
            stable_cnt_r <= '0;
            keys         <= '0;
            key_valid    <= 1'b0;
            key_event    <= 1'b0;
`ifdef KEYPAD_GHOST_REJECT_EN
            ghost        <= 1'b0;
`endif
        end else begin
            key_event <= 1'b0;
            if (scan_done_r) begin
                prev_raw_r   <= raw_r;
                stable_cnt_r <= stable_next_s;
`ifdef KEYPAD_GHOST_REJECT_EN
                ghost        <= ghosted_s;
`endif
                if (update_s) begin
                    keys      <= raw_r;
                    key_valid <= |raw_r;
                    key_event <= |(raw_r & ~keys);
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Directed self-checking bench for keypad_matrix_scanner (CLK_DIV=4, DEBOUNCE_SCANS=3).
// A behavioural keypad model turns the pressed-key vector into column levels.
module tb_keypad_matrix_scanner;

    logic        clk;
    logic        rst;
    logic [3:0]  col_in;
    logic [3:0]  row_out;
    logic [15:0] keys;
    logic        key_valid;
    logic        key_event;
`ifdef KEYPAD_GHOST_REJECT_EN
    logic        ghost;
`endif

    logic [15:0] pad;
    int          tests;
    int          failures;

    keypad_matrix_scanner #(.CLK_DIV(4), .DEBOUNCE_SCANS(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .col_in    (col_in),
        .row_out   (row_out),
        .keys      (keys),
        .key_valid (key_valid),
        .key_event (key_event)
`ifdef KEYPAD_GHOST_REJECT_EN
       ,.ghost     (ghost)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Passive matrix: a pressed key pulls its column low while its row is driven low
    always_comb begin
        col_in = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pad[r*4 + c] && !row_out[r]) begin
                    col_in[c] = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for keys to reach exp, counting key_event pulses seen on the way
    task automatic wait_keys(input string tag, input logic [15:0] exp, input int budget,
                             output int ev);
        logic ok;
        ok = 1'b0;
        ev = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (key_event === 1'b1) ev++;
            if (keys === exp) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_reached"}, {15'd0, ok}, 16'd1);
        check({tag, "_keys"}, keys, exp);
    endtask

    task automatic count_events(input int cycles, output int ev);
        ev = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (key_event === 1'b1) ev++;
        end
    endtask

    initial begin
        int ev;
        int bad;
        tests    = 0;
        failures = 0;
        pad      = 16'h0000;
        rst      = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset asserted mid-scan
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_async_row", {12'd0, row_out}, 16'h000E);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_row",   {12'd0, row_out},   16'h000E);
        check("rst_keys",  keys,               16'h0000);
        check("rst_valid", {15'd0, key_valid}, 16'h0000);
        check("rst_event", {15'd0, key_event}, 16'h0000);
        rst = 1'b0;

        // Row rotation, four cycles per row
        for (int i = 0; i < 16; i++) begin
            logic [3:0] exp_row;
            exp_row = ~(4'b0001 << (i / 4));
            check($sformatf("row_seq_%0d", i), {12'd0, row_out}, {12'd0, exp_row});
            @(negedge clk);
        end

        // Clean press of key 6, hold, release
        pad = 16'h0040;
        wait_keys("press6", 16'h0040, 72, ev);
        check("press6_event", 16'(ev), 16'd1);
        check("press6_valid", {15'd0, key_valid}, 16'd1);
        count_events(64, ev);
        check("hold6_no_event", 16'(ev), 16'd0);
        check("hold6_keys", keys, 16'h0040);
        pad = 16'h0000;
        wait_keys("rel6", 16'h0000, 72, ev);
        check("rel6_no_event", 16'(ev), 16'd0);
        check("rel6_valid", {15'd0, key_valid}, 16'd0);

        // Bounce: a 6-cycle toggle never lets three consecutive scans agree on key 6
        bad = 0;
        for (int i = 0; i < 102; i++) begin
            if (i % 6 == 0) pad = (pad == 16'h0000) ? 16'h0040 : 16'h0000;
            @(negedge clk);
            if (keys !== 16'h0000) bad++;
        end
        check("bounce_keys_held", 16'(bad), 16'd0);
        pad = 16'h0040;
        wait_keys("bounce_settle", 16'h0040, 72, ev);
        check("bounce_settle_event", 16'(ev), 16'd1);
        pad = 16'h0000;
        wait_keys("bounce_rel", 16'h0000, 72, ev);

        // Two keys: 0, then 0 + f
        pad = 16'h0001;
        wait_keys("key0", 16'h0001, 72, ev);
        check("key0_event", 16'(ev), 16'd1);
        pad = 16'h8001;
        wait_keys("key0f", 16'h8001, 72, ev);
        check("key0f_event", 16'(ev), 16'd1);
        pad = 16'h0001;
        wait_keys("rel_f", 16'h0001, 72, ev);
        check("rel_f_no_event", 16'(ev), 16'd0);

        // Swap key 0 for key 5 at once
        pad = 16'h0020;
        wait_keys("swap", 16'h0020, 72, ev);
        check("swap_event", 16'(ev), 16'd1);
        check("swap_valid", {15'd0, key_valid}, 16'd1);
        pad = 16'h0000;
        wait_keys("swap_rel", 16'h0000, 72, ev);
        check("swap_rel_valid", {15'd0, key_valid}, 16'd0);

        // Rectangle pattern: keys 0,1,4,5
        pad = 16'h0033;
`ifdef KEYPAD_GHOST_REJECT_EN
        bad = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (keys !== 16'h0000) bad++;
        end
        check("ghost_keys_held", 16'(bad), 16'd0);
        check("ghost_flag", {15'd0, ghost}, 16'd1);
        // Rows 0 and 1 now share only column 0, so the pattern is legal
        pad = 16'h0013;
        wait_keys("ghost_l", 16'h0013, 72, ev);
        check("ghost_l_flag", {15'd0, ghost}, 16'd0);
        check("ghost_l_event", 16'(ev), 16'd1);
        pad = 16'h0000;
        wait_keys("ghost_rel", 16'h0000, 72, ev);
        check("ghost_rel_flag", {15'd0, ghost}, 16'd0);
`else
        wait_keys("rect", 16'h0033, 72, ev);
        check("rect_event", 16'(ev), 16'd1);
        pad = 16'h0000;
        wait_keys("rect_rel", 16'h0000, 72, ev);
`endif
        check("final_valid", {15'd0, key_valid}, 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
